seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial pattern detector. Successor to the fixed three-ones detector.
- Detects a runtime-loadable PAT_W-bit pattern on a qualified serial bit stream.
- Selectable overlapping or non-overlapping match mode, with a saturating match counter.
- Sits on serial input lanes; z feeds downstream control logic, match_cnt feeds status readback.

Parameters:
PAT_W, 3, pattern length in bits (legal range 2..16)
CNT_W, 8, width of match counter

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-high
y  input  1  serial data bit
y_valid  input  1  y is sampled only when high
pat_load  input  1  load pat_in as the new pattern
pat_in  input  PAT_W  pattern; bit PAT_W-1 is the first bit received, bit 0 is the last
overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_cnt
z  output  1  registered match flag
match_cnt  output  CNT_W  saturating count of matches
armed  output  1  a pattern has been loaded since reset

Behaviour:
- Reset (rst high, asynchronous, any time):
  - state=UNARMED; z=0; match_cnt=0; armed=0.
  - Pattern register, history register and fill counter all cleared.
  - The loaded pattern is lost; a new pat_load is required.
- States:
  - UNARMED: y_valid is ignored; z=0. pat_load moves to SCAN.
  - SCAN: no match this cycle.
  - HIT: a match completed on the last edge; z=1 only in HIT.
- pat_load, legal in any state:
  - Next edge: pattern<=pat_in, history<=0, fill<=0, armed<=1, state<=SCAN, z<=0.
  - Takes priority over y_valid in the same cycle; that bit is discarded and neither shifted nor counted.
- Valid bit, in SCAN or HIT with y_valid=1 and pat_load=0:
  - history_next = {history[PAT_W-2:0], y}; newest bit at LSB.
  - fill_next = min(fill+1, PAT_W).
  - Match when fill_next==PAT_W and history_next==pattern.
  - On match: state<=HIT (z=1 the cycle after the edge that sampled the final bit); match_cnt increments.
  - No match: state<=SCAN.
- Overlap handling:
  - overlap=1: fill stays at PAT_W after a match, so back-to-back matches keep z high for consecutive valid cycles, one count each.
  - overlap=0: on a match, fill<=0 (history still shifts). The next match needs PAT_W fresh valid bits.
  - overlap is sampled at each valid bit, so a mode change applies to the next bit.
- y_valid=0 (armed):
  - history and fill hold.
  - HIT returns to SCAN, so z drops after exactly one cycle.
  - Gaps do not break a partial match.
- match_cnt:
  - Saturates at 2^CNT_W-1 and does not wrap; z still pulses at saturation.
  - cnt_clr with no match: 0 next edge.
  - cnt_clr and match in the same cycle: 1.
- All outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
1. Reset, load 3'b111, overlap=1, valid stream 1,1,1,1,1 → z high on 3 consecutive cycles starting one cycle after the 3rd bit; match_cnt=3.
2. Same stream with overlap=0 → match_cnt=1. Stream 1,1,1,1,1,1 → match_cnt=2, z pulses separated.
3. Load 3'b101. Stream 1,0,1,0,1 with overlap=1 → match_cnt=2; with overlap=0 → match_cnt=1. Stream 1,1,0,1 → match_cnt=1.
4. Pattern 111, bits 1,1,1 each separated by 2 cycles of y_valid=0 → single z pulse one cycle after the 3rd valid bit; z=0 during gaps.
5. Boundaries:
   - Before any pat_load, drive 1,1,1 valid → z=0, match_cnt=0, armed=0.
   - pat_load coincident with a valid 1 → that bit not counted toward the match.
   - rst pulse after bits 1,1, then 1 → no match, armed=0.
6. CNT_W=2, pattern 111, overlap=1, seven valid 1s → five matches, match_cnt saturates at 3. Then cnt_clr coincident with a match → match_cnt=1.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// Serial-lane bundle for the pattern detector: qualified bit stream and control in, match flag and status out.
// master drives the stream and control; slave is the detector.
interface seq_detect_param_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  logic             y;
  logic             y_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap;
  logic             cnt_clr;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output y, y_valid, pat_load, pat_in, overlap, cnt_clr,
    input  z, match_cnt, armed
  );

  modport slave (
    input  y, y_valid, pat_load, pat_in, overlap, cnt_clr,
    output z, match_cnt, armed
  );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-loadable PAT_W-bit serial pattern detector with overlap mode and a saturating match counter.
// z rises one cycle after the edge that samples the final bit; y_valid low stalls the matcher and never loses a partial match.
module seq_detect_param #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_param_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  generate
    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
      $error("seq_detect_param: PAT_W must be in 2..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    SCAN    = 2'd1,
    HIT     = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   pattern, pattern_nxt;
  logic [PAT_W-1:0]   history, history_nxt;
  logic [FILL_W-1:0]  fill, fill_nxt;
  logic [CNT_W-1:0]   match_cnt, cnt_nxt;
  logic               armed, armed_nxt;

  logic [PAT_W-1:0]   shifted;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UNARMED;
      pattern   <= '0;
      history   <= '0;
      fill      <= '0;
      match_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pattern   <= pattern_nxt;
      history   <= history_nxt;
      fill      <= fill_nxt;
      match_cnt <= cnt_nxt;
      armed     <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    history_nxt = history;
    fill_nxt    = fill;
    armed_nxt   = armed;
    cnt_nxt     = match_cnt;
    match       = 1'b0;
    shifted     = {history[PAT_W-2:0], bus.y};
    fill_inc    = (fill == FILL_FULL) ? fill : fill + 1'b1;

    // A load wins over a coincident valid bit, which is dropped entirely.
    if (bus.pat_load) begin
      pattern_nxt = bus.pat_in;
      history_nxt = '0;
      fill_nxt    = '0;
      armed_nxt   = 1'b1;
      state_nxt   = SCAN;
    end else if (state != UNARMED) begin
      if (bus.y_valid) begin
        history_nxt = shifted;
        match       = (fill_inc == FILL_FULL) && (shifted == pattern);
        fill_nxt    = (match && !bus.overlap) ? '0 : fill_inc;
        state_nxt   = match ? HIT : SCAN;
      end else begin
        state_nxt = SCAN;
      end
    end

    if (bus.cnt_clr) begin
      cnt_nxt = match ? CNT_W'(1) : '0;
    end else if (match && match_cnt != CNT_MAX) begin
      cnt_nxt = match_cnt + 1'b1;
    end
  end

  assign bus.z         = (state == HIT);
  assign bus.match_cnt = match_cnt;
  assign bus.armed     = armed;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: two instances, default counter width and a 2-bit counter for saturation.
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_W(3), .CNT_W(8)) sif ();
  seq_detect_param_if #(.PAT_W(3), .CNT_W(2)) cif ();

  seq_detect_param #(.PAT_W(3), .CNT_W(8)) dut   (.clk(clk), .rst(rst), .bus(sif));
  seq_detect_param #(.PAT_W(3), .CNT_W(2)) dut_c (.clk(clk), .rst(rst), .bus(cif));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    sif.y = 0; sif.y_valid = 0; sif.pat_load = 0; sif.pat_in = '0; sif.overlap = 0; sif.cnt_clr = 0;
    cif.y = 0; cif.y_valid = 0; cif.pat_load = 0; cif.pat_in = '0; cif.overlap = 0; cif.cnt_clr = 0;
  endtask

  task automatic do_reset();
    idle_all();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic load(input logic [2:0] pat, input logic ov);
    sif.pat_load = 1; sif.pat_in = pat; sif.overlap = ov;
    tick();
    sif.pat_load = 0;
  endtask

  task automatic send(input logic b, output logic zo);
    sif.y_valid = 1; sif.y = b;
    tick();
    zo = sif.z;
    sif.y_valid = 0;
  endtask

  task automatic test_reset();
    idle_all();
    @(negedge clk);
    rst = 1'b1;
    #2;
    n_total++; if (sif.z !== 1'b0) $display("FAIL reset_z got %b want 0", sif.z); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", sif.match_cnt); else n_pass++;
    n_total++; if (sif.armed !== 1'b0) $display("FAIL reset_armed got %b want 0", sif.armed); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unarmed();
    logic zo;
    logic zany = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin send(1'b1, zo); zany |= zo; end
    n_total++; if (zany !== 1'b0) $display("FAIL unarmed_z got %b want 0", zany); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd0) $display("FAIL unarmed_cnt got %0d want 0", sif.match_cnt); else n_pass++;
    n_total++; if (sif.armed !== 1'b0) $display("FAIL unarmed_armed got %b want 0", sif.armed); else n_pass++;
  endtask

  task automatic test_overlap();
    logic zo;
    logic [4:0] zv;
    do_reset();
    load(3'b111, 1'b1);
    n_total++; if (sif.armed !== 1'b1) $display("FAIL load_armed got %b want 1", sif.armed); else n_pass++;
    for (int i = 0; i < 5; i++) begin send(1'b1, zo); zv[i] = zo; end
    n_total++; if (zv !== 5'b11100) $display("FAIL ovl111_z got %b want 11100", zv); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd3) $display("FAIL ovl111_cnt got %0d want 3", sif.match_cnt); else n_pass++;
    tick();
    n_total++; if (sif.z !== 1'b0) $display("FAIL hit_drop_z got %b want 0", sif.z); else n_pass++;
  endtask

  task automatic test_non_overlap();
    logic zo;
    logic [5:0] zv;
    do_reset();
    load(3'b111, 1'b0);
    zv = '0;
    for (int i = 0; i < 5; i++) begin send(1'b1, zo); zv[i] = zo; end
    n_total++; if (zv[4:0] !== 5'b00100) $display("FAIL nov5_z got %b want 00100", zv[4:0]); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd1) $display("FAIL nov5_cnt got %0d want 1", sif.match_cnt); else n_pass++;
    do_reset();
    load(3'b111, 1'b0);
    for (int i = 0; i < 6; i++) begin send(1'b1, zo); zv[i] = zo; end
    n_total++; if (zv !== 6'b100100) $display("FAIL nov6_z got %b want 100100", zv); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd2) $display("FAIL nov6_cnt got %0d want 2", sif.match_cnt); else n_pass++;
  endtask

  task automatic test_pat101();
    logic zo;
    logic [4:0] zv;
    logic [4:0] s5;
    logic [3:0] s4;
    s5 = 5'b10101;
    s4 = 4'b1011;
    do_reset();
    load(3'b101, 1'b1);
    for (int i = 0; i < 5; i++) begin send(s5[i], zo); zv[i] = zo; end
    n_total++; if (zv !== 5'b10100) $display("FAIL p101_ovl_z got %b want 10100", zv); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd2) $display("FAIL p101_ovl_cnt got %0d want 2", sif.match_cnt); else n_pass++;
    do_reset();
    load(3'b101, 1'b0);
    for (int i = 0; i < 5; i++) begin send(s5[i], zo); zv[i] = zo; end
    n_total++; if (zv !== 5'b00100) $display("FAIL p101_nov_z got %b want 00100", zv); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd1) $display("FAIL p101_nov_cnt got %0d want 1", sif.match_cnt); else n_pass++;
    do_reset();
    load(3'b101, 1'b1);
    // s4 sent LSB first: 1,1,0,1
    zv = '0;
    for (int i = 0; i < 4; i++) begin send(s4[i], zo); zv[i] = zo; end
    n_total++; if (zv[3:0] !== 4'b1000) $display("FAIL p101_1101_z got %b want 1000", zv[3:0]); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd1) $display("FAIL p101_1101_cnt got %0d want 1", sif.match_cnt); else n_pass++;
  endtask

  task automatic test_gaps();
    logic zo;
    logic zgap = 0;
    do_reset();
    load(3'b111, 1'b1);
    for (int b = 0; b < 2; b++) begin
      send(1'b1, zo); zgap |= zo;
      for (int g = 0; g < 2; g++) begin tick(); zgap |= sif.z; end
    end
    send(1'b1, zo);
    n_total++; if (zgap !== 1'b0) $display("FAIL gap_z got %b want 0", zgap); else n_pass++;
    n_total++; if (zo !== 1'b1) $display("FAIL gap_hit_z got %b want 1", zo); else n_pass++;
    tick();
    n_total++; if (sif.z !== 1'b0) $display("FAIL gap_after_z got %b want 0", sif.z); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd1) $display("FAIL gap_cnt got %0d want 1", sif.match_cnt); else n_pass++;
  endtask

  task automatic test_load_coincident();
    logic zo;
    logic [2:0] zv;
    do_reset();
    load(3'b111, 1'b1);
    send(1'b1, zo);
    send(1'b1, zo);
    sif.pat_load = 1; sif.pat_in = 3'b111; sif.y_valid = 1; sif.y = 1;
    tick();
    sif.pat_load = 0; sif.y_valid = 0;
    n_total++; if (sif.z !== 1'b0) $display("FAIL ldco_z got %b want 0", sif.z); else n_pass++;
    for (int i = 0; i < 3; i++) begin send(1'b1, zo); zv[i] = zo; end
    n_total++; if (zv !== 3'b100) $display("FAIL ldco_seq_z got %b want 100", zv); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd1) $display("FAIL ldco_cnt got %0d want 1", sif.match_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic zo;
    do_reset();
    load(3'b111, 1'b1);
    send(1'b1, zo);
    send(1'b1, zo);
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    send(1'b1, zo);
    n_total++; if (zo !== 1'b0) $display("FAIL rstmid_z got %b want 0", zo); else n_pass++;
    n_total++; if (sif.match_cnt !== 8'd0) $display("FAIL rstmid_cnt got %0d want 0", sif.match_cnt); else n_pass++;
    n_total++; if (sif.armed !== 1'b0) $display("FAIL rstmid_armed got %b want 0", sif.armed); else n_pass++;
  endtask

  task automatic test_saturate();
    int zcount = 0;
    do_reset();
    cif.pat_load = 1; cif.pat_in = 3'b111; cif.overlap = 1;
    tick();
    cif.pat_load = 0;
    for (int i = 0; i < 7; i++) begin
      cif.y_valid = 1; cif.y = 1;
      tick();
      if (cif.z === 1'b1) zcount++;
    end
    n_total++; if (zcount != 5) $display("FAIL sat_zcount got %0d want 5", zcount); else n_pass++;
    n_total++; if (cif.match_cnt !== 2'd3) $display("FAIL sat_cnt got %0d want 3", cif.match_cnt); else n_pass++;
    cif.cnt_clr = 1;
    tick();
    n_total++; if (cif.z !== 1'b1) $display("FAIL clr_match_z got %b want 1", cif.z); else n_pass++;
    n_total++; if (cif.match_cnt !== 2'd1) $display("FAIL clr_match_cnt got %0d want 1", cif.match_cnt); else n_pass++;
    cif.y_valid = 0;
    tick();
    cif.cnt_clr = 0;
    n_total++; if (cif.match_cnt !== 2'd0) $display("FAIL clr_idle_cnt got %0d want 0", cif.match_cnt); else n_pass++;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_unarmed();
    test_overlap();
    test_non_overlap();
    test_pat101();
    test_gaps();
    test_load_coincident();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
